// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the fetch stage and its neighbours.
//   ADDR_W      : instruction address width (8 bits, 256 words)
//   BR_*        : branch_op codes driven by the control decoder
//   FLAG_*      : bit positions inside the {Z,N,C,V} status register
//   branch_taken: evaluates a branch class against a status register value
package cpu_pkg;

  localparam int ADDR_W = 8;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam logic [3:0] BR_NONE = 4'd0;
  localparam logic [3:0] BR_JMP  = 4'd1;
  localparam logic [3:0] BR_JEQ  = 4'd2;
  localparam logic [3:0] BR_JNE  = 4'd3;
  localparam logic [3:0] BR_JGT  = 4'd4;
  localparam logic [3:0] BR_JLT  = 4'd5;
  localparam logic [3:0] BR_JGE  = 4'd6;
  localparam logic [3:0] BR_JLE  = 4'd7;
  localparam logic [3:0] BR_JCR  = 4'd8;
  localparam logic [3:0] BR_JOV  = 4'd9;
  localparam logic [3:0] BR_CALL = 4'd10;
  localparam logic [3:0] BR_RET  = 4'd11;
  localparam logic [3:0] BR_HLT  = 4'd12;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Only the jump classes JMP..JOV are evaluated here; every other code
  // (including CALL/RET/HLT, which are handled by the caller) returns 0.
  function automatic logic branch_taken(input logic [3:0] op, input logic [3:0] f);
    logic z, n, c, v;
    z = f[FLAG_Z];
    n = f[FLAG_N];
    c = f[FLAG_C];
    v = f[FLAG_V];
    case (op)
      BR_JMP:  return 1'b1;
      BR_JEQ:  return z;
      BR_JNE:  return !z;
      BR_JGT:  return !n && !z;
      BR_JLT:  return n;
      BR_JGE:  return !n;
      BR_JLE:  return n || z;
      BR_JCR:  return c;
      BR_JOV:  return v;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundle between the control/ALU side (master) and the
// fetch stage (slave).
//   branch_op, target          : branch class and destination from decode
//   alu_z/n/c/v, flags_we      : live ALU flags and their latch enable
//   stall                      : hold PC and stack this cycle
//   pc, flags, halted, stack_err: fetch-stage state returned to the core
interface fetch_unit_if;
  import cpu_pkg::*;

  logic [3:0] branch_op;
  addr_t      target;
  logic       alu_z;
  logic       alu_n;
  logic       alu_c;
  logic       alu_v;
  logic       flags_we;
  logic       stall;
  addr_t      pc;
  logic [3:0] flags;
  logic       halted;
  logic       stack_err;

  modport master (
    output branch_op, target, alu_z, alu_n, alu_c, alu_v, flags_we, stall,
    input  pc, flags, halted, stack_err
  );

  modport slave (
    input  branch_op, target, alu_z, alu_n, alu_c, alu_v, flags_we, stall,
    output pc, flags, halted, stack_err
  );
endinterface

// File: rtl/return_stack.sv
// return_stack: LIFO of return addresses for CALL/RET.
//   clk, reset : clock and synchronous active-high reset (empties the stack)
//   push, din  : write din on top when not full
//   pop        : discard top entry when not empty
//   dout       : current top entry, combinational so RET can use it at once
//   full, empty: occupancy status
module return_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  logic  pop,
  input  addr_t din,
  output addr_t dout,
  output logic  full,
  output logic  empty
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  addr_t         mem [DEPTH];
  logic [PW-1:0] sp_reg;
  logic [PW-1:0] top_idx;

  assign full    = (sp_reg == PW'(DEPTH));
  assign empty   = (sp_reg == '0);
  assign top_idx = sp_reg - PW'(1);
  assign dout    = empty ? '0 : mem[AW'(top_idx)];

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_reg <= '0;
    end else if (push && !full) begin
      sp_reg <= sp_reg + PW'(1);
    end else if (pop && !empty) begin
      sp_reg <= sp_reg - PW'(1);
    end
  end

  // Entries carry no reset; the stack pointer alone defines validity.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && !full && sp_reg == PW'(gi)) begin
        mem[gi] <= din;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, status register and branch resolution.
//   clk, reset : clock and synchronous active-high reset
//   bus (slave): branch_op/target/ALU flags/flags_we/stall in,
//                pc/flags/halted/stack_err out
// Build option: define FETCH_CALL_STACK_EN to add the CALL/RET return
// stack (depth STACK_DEPTH). Without it, CALL and RET behave as NONE and
// stack_err is constant 0.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.slave  bus
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t     state_reg;
  addr_t      pc_reg;
  addr_t      pc_next;
  addr_t      pc_plus1;
  logic [3:0] flags_reg;
  logic       halted_reg;
  logic       halt_req;
  logic       advance;

  // Stack and PC only move when running and not stalled.
  assign advance  = (state_reg == ST_RUN) && !bus.stall;
  assign pc_plus1 = pc_reg + addr_t'(1);

`ifdef FETCH_CALL_STACK_EN
  logic  push_req;
  logic  pop_req;
  logic  err_req;
  logic  stk_full;
  logic  stk_empty;
  addr_t stk_top;
  logic  stack_err_reg;

  return_stack #(.DEPTH(STACK_DEPTH)) u_return_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push_req && advance),
    .pop   (pop_req && advance),
    .din   (pc_plus1),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign bus.stack_err = stack_err_reg;
`else
  logic [7:0] depth_unused;
  assign depth_unused  = 8'(STACK_DEPTH);
  assign bus.stack_err = 1'b0;
`endif

  // Branch resolution uses the registered flags so a compare followed by
  // a conditional jump works across two instructions.
  always_comb begin
    pc_next  = pc_plus1;
    halt_req = 1'b0;
`ifdef FETCH_CALL_STACK_EN
    push_req = 1'b0;
    pop_req  = 1'b0;
    err_req  = 1'b0;
`endif
    case (bus.branch_op)
      BR_JMP, BR_JEQ, BR_JNE, BR_JGT, BR_JLT,
      BR_JGE, BR_JLE, BR_JCR, BR_JOV: begin
        if (branch_taken(bus.branch_op, flags_reg)) begin
          pc_next = bus.target;
        end
      end
`ifdef FETCH_CALL_STACK_EN
      BR_CALL: begin
        if (stk_full) begin
          err_req  = 1'b1;
          halt_req = 1'b1;
          pc_next  = pc_reg;
        end else begin
          push_req = 1'b1;
          pc_next  = bus.target;
        end
      end
      BR_RET: begin
        if (stk_empty) begin
          err_req  = 1'b1;
          halt_req = 1'b1;
          pc_next  = pc_reg;
        end else begin
          pop_req = 1'b1;
          pc_next = stk_top;
        end
      end
`endif
      BR_HLT: begin
        halt_req = 1'b1;
        pc_next  = pc_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_RUN;
      pc_reg        <= '0;
      flags_reg     <= '0;
      halted_reg    <= 1'b0;
`ifdef FETCH_CALL_STACK_EN
      stack_err_reg <= 1'b0;
`endif
    end else if (state_reg == ST_RUN) begin
      // Flag latching is independent of stall.
      if (bus.flags_we) begin
        flags_reg <= {bus.alu_z, bus.alu_n, bus.alu_c, bus.alu_v};
      end
      if (advance) begin
        pc_reg <= pc_next;
        if (halt_req) begin
          state_reg  <= ST_HALT;
          halted_reg <= 1'b1;
        end
`ifdef FETCH_CALL_STACK_EN
        if (err_req) begin
          stack_err_reg <= 1'b1;
        end
`endif
      end
    end
  end

  assign bus.pc     = pc_reg;
  assign bus.flags  = flags_reg;
  assign bus.halted = halted_reg;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;

  fetch_unit_if bus ();

  fetch_unit #(.STACK_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] op;
    logic [7:0] tgt;
    logic [3:0] alu;
    logic       we;
    logic       st;
    logic [7:0] exp_pc;
    logic [3:0] exp_flags;
    logic       exp_halted;
  } vec_t;

  typedef struct {
    logic [7:0] pc;
    logic [3:0] flags;
    logic       halted;
    logic       err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic rst, logic [3:0] op, logic [7:0] tgt, logic [3:0] alu,
                              logic we, logic st, logic [7:0] epc, logic [3:0] ef, logic eh);
    vec_t v;
    v.rst = rst; v.op = op; v.tgt = tgt; v.alu = alu; v.we = we; v.st = st;
    v.exp_pc = epc; v.exp_flags = ef; v.exp_halted = eh;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expectation, compare after the edge.
  task automatic step(input string name, input logic rst, input logic [3:0] op,
                      input logic [7:0] tgt, input logic [3:0] alu, input logic we,
                      input logic st, input logic [7:0] epc, input logic [3:0] ef,
                      input logic eh, input logic ee);
    exp_t e;
    exp_t got;
    @(negedge clk);
    reset         = rst;
    bus.branch_op = op;
    bus.target    = tgt;
    {bus.alu_z, bus.alu_n, bus.alu_c, bus.alu_v} = alu;
    bus.flags_we  = we;
    bus.stall     = st;
    e.pc = epc; e.flags = ef; e.halted = eh; e.err = ee;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    $display("[%0t] %s rst=%0b op=%0d tgt=%02h we=%0b st=%0b -> pc=%02h flags=%h halted=%0b err=%0b",
             $time, name, rst, op, tgt, we, st, bus.pc, bus.flags, bus.halted, bus.stack_err);
    check({name, ".pc"},        32'(bus.pc),        32'(got.pc));
    check({name, ".flags"},     32'(bus.flags),     32'(got.flags));
    check({name, ".halted"},    32'(bus.halted),    32'(got.halted));
    check({name, ".stack_err"}, 32'(bus.stack_err), 32'(got.err));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.branch_op = BR_NONE;
    bus.target = '0;
    {bus.alu_z, bus.alu_n, bus.alu_c, bus.alu_v} = 4'b0000;
    bus.flags_we = 1'b0;
    bus.stall = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset.pc",        32'(bus.pc),        32'h0);
    check("reset.flags",     32'(bus.flags),     32'h0);
    check("reset.halted",    32'(bus.halted),    32'h0);
    check("reset.stack_err", 32'(bus.stack_err), 32'h0);

    //             rst  op       tgt    alu      we  st  pc     flags    h
    vecs.push_back(mk(0, BR_NONE, 8'h00, 4'b0000, 0, 0, 8'h01, 4'h0, 0));
    vecs.push_back(mk(0, BR_NONE, 8'h00, 4'b0000, 0, 0, 8'h02, 4'h0, 0));
    vecs.push_back(mk(0, BR_NONE, 8'h00, 4'b1111, 1, 0, 8'h03, 4'hF, 0));
    vecs.push_back(mk(1, BR_NONE, 8'h00, 4'b0000, 0, 0, 8'h00, 4'h0, 0));
    vecs.push_back(mk(0, BR_NONE, 8'h00, 4'b0000, 0, 0, 8'h01, 4'h0, 0));
    vecs.push_back(mk(0, BR_NONE, 8'h00, 4'b0000, 0, 0, 8'h02, 4'h0, 0));
    vecs.push_back(mk(0, BR_NONE, 8'h00, 4'b0000, 0, 0, 8'h03, 4'h0, 0));
    vecs.push_back(mk(0, BR_NONE, 8'h00, 4'b0000, 0, 0, 8'h04, 4'h0, 0));
    vecs.push_back(mk(0, BR_NONE, 8'h00, 4'b0000, 0, 0, 8'h05, 4'h0, 0));
    vecs.push_back(mk(0, BR_NONE, 8'h00, 4'b1000, 1, 0, 8'h06, 4'h8, 0));
    vecs.push_back(mk(0, BR_JEQ,  8'h40, 4'b0000, 0, 0, 8'h40, 4'h8, 0));
    vecs.push_back(mk(0, BR_NONE, 8'h00, 4'b0000, 1, 0, 8'h41, 4'h0, 0));
    vecs.push_back(mk(0, BR_JEQ,  8'h40, 4'b0000, 0, 0, 8'h42, 4'h0, 0));
    vecs.push_back(mk(0, BR_JNE,  8'h80, 4'b0000, 0, 0, 8'h80, 4'h0, 0));
    vecs.push_back(mk(0, BR_JEQ,  8'h10, 4'b1000, 1, 0, 8'h81, 4'h8, 0)); // old Z used
    vecs.push_back(mk(0, BR_JNE,  8'h10, 4'b0000, 0, 0, 8'h82, 4'h8, 0));
    vecs.push_back(mk(0, BR_NONE, 8'h00, 4'b0100, 1, 0, 8'h83, 4'h4, 0));
    vecs.push_back(mk(0, BR_JLT,  8'h30, 4'b0000, 0, 0, 8'h30, 4'h4, 0));
    vecs.push_back(mk(0, BR_JGT,  8'h50, 4'b0000, 0, 0, 8'h31, 4'h4, 0));
    vecs.push_back(mk(0, BR_JGE,  8'h50, 4'b0000, 0, 0, 8'h32, 4'h4, 0));
    vecs.push_back(mk(0, BR_JLE,  8'h60, 4'b0000, 0, 0, 8'h60, 4'h4, 0));
    vecs.push_back(mk(0, BR_NONE, 8'h00, 4'b0011, 1, 0, 8'h61, 4'h3, 0));
    vecs.push_back(mk(0, BR_JCR,  8'h70, 4'b0000, 0, 0, 8'h70, 4'h3, 0));
    vecs.push_back(mk(0, BR_JOV,  8'hA0, 4'b0000, 0, 0, 8'hA0, 4'h3, 0));
    vecs.push_back(mk(0, BR_JGT,  8'h20, 4'b0000, 0, 0, 8'h20, 4'h3, 0));
    vecs.push_back(mk(0, BR_JGE,  8'h90, 4'b0000, 0, 0, 8'h90, 4'h3, 0));
    vecs.push_back(mk(0, BR_JLE,  8'h11, 4'b0000, 0, 0, 8'h91, 4'h3, 0));
    vecs.push_back(mk(0, 4'd13,   8'h55, 4'b0000, 0, 0, 8'h92, 4'h3, 0));
    vecs.push_back(mk(0, 4'd15,   8'h55, 4'b0000, 0, 0, 8'h93, 4'h3, 0));
    vecs.push_back(mk(0, BR_JMP,  8'hFF, 4'b0000, 0, 0, 8'hFF, 4'h3, 0));
    vecs.push_back(mk(0, BR_NONE, 8'h00, 4'b0000, 0, 0, 8'h00, 4'h3, 0)); // wrap
    vecs.push_back(mk(0, BR_JMP,  8'h10, 4'b1000, 1, 1, 8'h00, 4'h8, 0)); // stall, flags still latch
    vecs.push_back(mk(0, BR_JMP,  8'h10, 4'b0000, 0, 0, 8'h10, 4'h8, 0));
    vecs.push_back(mk(0, BR_HLT,  8'h00, 4'b0000, 0, 1, 8'h10, 4'h8, 0)); // stalled HLT ignored
    vecs.push_back(mk(0, BR_JCR,  8'h40, 4'b0000, 0, 0, 8'h11, 4'h8, 0));
    vecs.push_back(mk(0, BR_JEQ,  8'h50, 4'b0000, 0, 0, 8'h50, 4'h8, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].op, vecs[i].tgt, vecs[i].alu,
           vecs[i].we, vecs[i].st, vecs[i].exp_pc, vecs[i].exp_flags, vecs[i].exp_halted, 1'b0);
    end

`ifdef FETCH_CALL_STACK_EN
    step("stk.rst",   1, BR_NONE, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0);
    step("stk.jmp",   0, BR_JMP,  8'h08, 4'h0, 0, 0, 8'h08, 4'h0, 0, 0);
    step("stk.call",  0, BR_CALL, 8'h20, 4'h0, 0, 0, 8'h20, 4'h0, 0, 0);
    step("stk.ret",   0, BR_RET,  8'h00, 4'h0, 0, 0, 8'h09, 4'h0, 0, 0);
    step("stk.c1",    0, BR_CALL, 8'h30, 4'h0, 0, 0, 8'h30, 4'h0, 0, 0);
    step("stk.c2",    0, BR_CALL, 8'h40, 4'h0, 0, 0, 8'h40, 4'h0, 0, 0);
    step("stk.c3",    0, BR_CALL, 8'h50, 4'h0, 0, 0, 8'h50, 4'h0, 0, 0);
    step("stk.c4",    0, BR_CALL, 8'h60, 4'h0, 0, 0, 8'h60, 4'h0, 0, 0);
    step("stk.ovf",   0, BR_CALL, 8'h70, 4'h0, 0, 0, 8'h60, 4'h0, 1, 1);
    step("stk.frz1",  0, BR_NONE, 8'h00, 4'hF, 1, 0, 8'h60, 4'h0, 1, 1);
    step("stk.frz2",  0, BR_RET,  8'h00, 4'h0, 0, 0, 8'h60, 4'h0, 1, 1);
    step("stk.rst2",  1, BR_NONE, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0);
    step("stk.udf",   0, BR_RET,  8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 1, 1);
    step("stk.rst3",  1, BR_NONE, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0);
    // Nested return order after the error recovery
    step("stk.n1",    0, BR_CALL, 8'h30, 4'h0, 0, 0, 8'h30, 4'h0, 0, 0);
    step("stk.n2",    0, BR_CALL, 8'h80, 4'h0, 0, 0, 8'h80, 4'h0, 0, 0);
    step("stk.r2",    0, BR_RET,  8'h00, 4'h0, 0, 0, 8'h31, 4'h0, 0, 0);
    step("stk.r1",    0, BR_RET,  8'h00, 4'h0, 0, 0, 8'h01, 4'h0, 0, 0);
`else
    step("nostk.rst", 1, BR_NONE, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0);
    step("nostk.jmp", 0, BR_JMP,  8'h08, 4'h0, 0, 0, 8'h08, 4'h0, 0, 0);
    step("nostk.call",0, BR_CALL, 8'h20, 4'h0, 0, 0, 8'h09, 4'h0, 0, 0);
    step("nostk.ret", 0, BR_RET,  8'h00, 4'h0, 0, 0, 8'h0A, 4'h0, 0, 0);
    step("nostk.ret2",0, BR_RET,  8'h00, 4'h0, 0, 0, 8'h0B, 4'h0, 0, 0);
`endif

    // HLT and the frozen HALT state
    step("hlt.rst",  1, BR_NONE, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0);
    step("hlt.jmp",  0, BR_JMP,  8'h0C, 4'h0, 0, 0, 8'h0C, 4'h0, 0, 0);
    step("hlt.hlt",  0, BR_HLT,  8'h00, 4'h0, 0, 0, 8'h0C, 4'h0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step($sformatf("hlt.frz%0d", i), 0, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
           4'hF, 1, 1'($urandom_range(0, 1)), 8'h0C, 4'h0, 1, 0);
    end
    step("hlt.rst2", 1, BR_JMP,  8'h33, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0);
    step("hlt.run",  0, BR_NONE, 8'h00, 4'h0, 0, 0, 8'h01, 4'h0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
